// File: rtl/isa_defs_pkg.sv
// isa_defs: opcode constants, fetch FSM encoding and instruction length rule
// shared by the program memories, the fetch unit and the decoder.
package isa_defs;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_MOV = 4'h3;
    localparam logic [3:0] OP_NOP = 4'h4;

    localparam logic [5:0] OP_LD_IMM     = 6'b100000;
    localparam logic [5:0] OP_LD_MEM     = 6'b100001;
    localparam logic [5:0] OP_DEC        = 6'b100010;
    localparam logic [5:0] OP_CMP        = 6'b100011;
    localparam logic [5:0] OP_INPUT      = 6'b100100;
    localparam logic [5:0] OP_OUTPUT     = 6'b100101;
    localparam logic [5:0] OP_LD_MEM_REG = 6'b100110;
    localparam logic [5:0] OP_BRA        = 6'b101010;
    localparam logic [5:0] OP_BHI        = 6'b101100;
    localparam logic [5:0] OP_BEQ        = 6'b101101;

    typedef enum logic [1:0] {
        S_OP    = 2'd0,
        S_IMM   = 2'd1,
        S_VALID = 2'd2
    } ifu_state_e;

    // Short-form opcodes (bit 7 clear) never carry an immediate.
    function automatic logic is_two_byte(input logic [7:0] b);
        return b[7] && (b[7:2] inside {OP_LD_IMM, OP_LD_MEM, OP_CMP, OP_BRA, OP_BHI, OP_BEQ});
    endfunction

endpackage

// File: rtl/ifu_length_decode.sv
// ifu_length_decode: flags opcode bytes that are followed by an immediate byte.
module ifu_length_decode
    import isa_defs::*;
(
    input  logic [7:0] opcode_i,
    output logic       two_byte_o
);

    assign two_byte_o = is_two_byte(opcode_i);

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: walks the program ROM, assembles 1/2-byte instructions
// and presents them to decode over valid/ready; branch redirects win in every state.
module instruction_fetch_unit
    import isa_defs::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'd0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_bus,
    input  logic [7:0]        data_bus,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_op,
    output logic [7:0]        instr_imm,
    output logic              instr_two_byte,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
    logic [7:0]        op_q, op_d, imm_q, imm_d;
    logic              two_q, two_d, valid_q, valid_d;
    logic              two_byte;

    ifu_length_decode u_len (
        .opcode_i   (data_bus),
        .two_byte_o (two_byte)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_OP;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            op_q    <= '0;
            imm_q   <= '0;
            two_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            two_q   <= two_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        op_d    = op_q;
        imm_d   = imm_q;
        two_d   = two_q;
        case (state_q)
            S_OP: begin
                op_d    = data_bus;
                ipc_d   = pc_q;
                pc_d    = pc_q + 1'b1;
                state_d = two_byte ? S_IMM : S_VALID;
                imm_d   = two_byte ? imm_q : 8'h00;
                two_d   = two_byte ? two_q : 1'b0;
            end
            S_IMM: begin
                imm_d   = data_bus;
                two_d   = 1'b1;
                pc_d    = pc_q + 1'b1;
                state_d = S_VALID;
            end
            S_VALID: state_d = instr_ready ? S_OP : S_VALID;
            default: state_d = S_OP;
        endcase
        // A redirect drops any partial or pending instruction.
        if (branch_valid) begin
            pc_d    = branch_target;
            state_d = S_OP;
        end
        valid_d = (state_d == S_VALID);
    end

    assign address_bus    = pc_q;
    assign instr_valid    = valid_q;
    assign instr_op       = op_q;
    assign instr_imm      = imm_q;
    assign instr_two_byte = two_q;
    assign instr_pc       = ipc_q;

endmodule
